regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Clocked, parametrised successor to the 8x16 LC-3 register file.
- Provides two read ports and one write port:
  - synchronous write;
  - registered reads, with write-to-read bypass;
  - a per-register scoreboard of pending writes, which generates a read stall and an issue stall for the pipelined datapath.
- Sits between decode/issue (SR1, SR2, issue DR) and writeback (DR, DR_IN, LD).

Parameters:
- DATA_SIZE, 16, register width in bits.
- ADDR_SIZE, 3, address width; depth = 2**ADDR_SIZE registers.
- ZERO_REG, 0; when 1, R0 reads as 0 and writes to R0 are discarded.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- SR1, SR2  input  ADDR_SIZE  read addresses.
- RD_EN  input  1  read request.
- SR1_OUT, SR2_OUT  output  DATA_SIZE  registered read data.
- RD_VALID  output  1  high for one cycle when SR1_OUT/SR2_OUT are updated.
- RD_STALL  output  1  combinational; the read is blocked by a pending source register.
- ISSUE_EN  input  1  marks ISSUE_DR as pending write.
- ISSUE_DR  input  ADDR_SIZE  destination register being issued.
- ISSUE_STALL  output  1  combinational; ISSUE_DR is already pending, so the issue is refused.
- LD  input  1  writeback enable.
- DR  input  ADDR_SIZE  writeback address.
- DR_IN  input  DATA_SIZE  writeback data.
- CC_NZP  output  3  condition codes {N,Z,P}; see Optional Feature.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all registers = 0;
  - all pending bits = 0;
  - SR1_OUT = SR2_OUT = 0, RD_VALID = 0;
  - CC_NZP = 3'b010.
- Write:
  - When LD is high, reg[DR] <= DR_IN on the edge and pend[DR] is cleared.
  - When ZERO_REG=1 and DR=0, the write is discarded (the pending bit is still cleared).
- Read latency is 1 cycle:
  - when RD_EN && !RD_STALL, SRx_OUT <= value(SRx) on the edge and RD_VALID <= 1;
  - otherwise SRx_OUT holds and RD_VALID <= 0.
- Bypass:
  - value(SRx) = DR_IN if LD && DR==SRx (and not a discarded R0 write), else reg[SRx];
  - with ZERO_REG=1, SRx=0 always yields 0.
- RD_STALL:
  - = RD_EN && (blocked(SR1) || blocked(SR2));
  - blocked(a) = pend[a] && !(LD && DR==a);
  - so a same-cycle writeback resolves the hazard without a stall.
- Issue:
  - ISSUE_STALL = ISSUE_EN && pend[ISSUE_DR] && !(LD && DR==ISSUE_DR);
  - when ISSUE_EN && !ISSUE_STALL, pend[ISSUE_DR] <= 1;
  - a refused issue changes no state.
- Simultaneous issue and writeback to the same register: the set wins, so pend stays 1 (the new write is outstanding).
- ZERO_REG=1: pend[0] is never set; issues to R0 never stall.
- Reads and issue are independent; the same cycle may carry a read, an issue and a writeback.
- Address wrap: none. All addresses are full-range; no out-of-range case exists.

Optional Feature:
- Macro REGFILE_CC_EN.
- Defined:
  - on every accepted LD write (including a discarded R0 write), CC_NZP <= {DR_IN[MSB], DR_IN==0, !DR_IN[MSB] && DR_IN!=0};
  - exactly one bit is set;
  - reset value is 3'b010.
- Undefined:
  - CC_NZP is tied to 3'b000;
  - no condition-code flops are built.
- The port list is identical in both builds.

Decomposition:
- Package regfile_pkg:
  - default DATA_SIZE/ADDR_SIZE constants;
  - CC_N/CC_Z/CC_P bit-index constants;
  - CC reset value 3'b010;
  - the nzp_t 3-bit typedef.
- One sub-module: regfile_scoreboard.
  - Owns the pend vector and produces RD_STALL/ISSUE_STALL.
  - Inputs: SR1, SR2, RD_EN, ISSUE_EN, ISSUE_DR, LD, DR.
- Storage, bypass muxes and the CC logic stay in regfile_sb.

Test Plan:
- Reset, then read: RST pulse, then RD_EN with SR1=3, SR2=7 → next cycle SR1_OUT=0, SR2_OUT=0, RD_VALID=1 for one cycle; CC_NZP=3'b010 with REGFILE_CC_EN.
- Write then read: LD, DR=5, DR_IN=16'h1234; next cycle RD_EN, SR1=5 → SR1_OUT=16'h1234 one cycle later. Then assert RST mid-read → outputs are 0 immediately.
- Bypass: LD, DR=2, DR_IN=16'hBEEF and RD_EN, SR2=2 in the same cycle → next cycle SR2_OUT=16'hBEEF, RD_VALID=1, RD_STALL=0.
- Scoreboard sequence:
  - ISSUE_EN, ISSUE_DR=4, then RD_EN with SR1=4 → RD_STALL=1, SR1_OUT held, RD_VALID=0;
  - writeback LD, DR=4, DR_IN=16'h0042 in the same cycle → RD_STALL=0, SR1_OUT=16'h0042 next cycle.
- Issue conflict:
  - ISSUE_DR=6 twice without writeback → second cycle ISSUE_STALL=1 and pend unchanged;
  - simultaneous issue and LD to R6 → ISSUE_STALL=0 and pend[6] stays 1.
- CC and ZERO_REG:
  - with REGFILE_CC_EN, write 16'h8000 → CC_NZP=100; write 0 → 010; write 16'h0001 → 001;
  - with ZERO_REG=1, LD DR=0, DR_IN=16'hFFFF → a later read of R0 returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, condition-code layout and helper for the regfile_sb slice
package regfile_pkg;
    localparam int DATA_SIZE_DEF = 16;
    localparam int ADDR_SIZE_DEF = 3;
    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;
    typedef logic [2:0] nzp_t;
    localparam nzp_t CC_RST = 3'b010;
    // Exactly one of N/Z/P is set for any value.
    function automatic nzp_t nzp_of(input logic neg, input logic zero);
        nzp_t cc;
        cc[CC_N] = neg;
        cc[CC_Z] = zero;
        cc[CC_P] = !neg && !zero;
        return cc;
    endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/issue/writeback bus of the register file
//   master: drives sr1/sr2/rd_en, issue_en/issue_dr, ld/dr/dr_in
//   slave : drives sr1_out/sr2_out/rd_valid, rd_stall/issue_stall, cc_nzp
interface regfile_sb_if import regfile_pkg::*; #(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
);
    logic [ADDR_SIZE-1:0] sr1, sr2, issue_dr, dr;
    logic                 rd_en, issue_en, ld;
    logic [DATA_SIZE-1:0] dr_in, sr1_out, sr2_out;
    logic                 rd_valid, rd_stall, issue_stall;
    nzp_t                 cc_nzp;
    modport master (
        output sr1, sr2, rd_en, issue_en, issue_dr, ld, dr, dr_in,
        input  sr1_out, sr2_out, rd_valid, rd_stall, issue_stall, cc_nzp
    );
    modport slave (
        input  sr1, sr2, rd_en, issue_en, issue_dr, ld, dr, dr_in,
        output sr1_out, sr2_out, rd_valid, rd_stall, issue_stall, cc_nzp
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bits per register, read and issue stall generation
//   in : clk, rst (async, active high), sr1, sr2, rd_en, issue_en, issue_dr, ld, dr
//   out: rd_stall, issue_stall
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int ZERO_REG  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] sr1,
    input  logic [ADDR_SIZE-1:0] sr2,
    input  logic                 rd_en,
    input  logic                 issue_en,
    input  logic [ADDR_SIZE-1:0] issue_dr,
    input  logic                 ld,
    input  logic [ADDR_SIZE-1:0] dr,
    output logic                 rd_stall,
    output logic                 issue_stall
);
    localparam int DEPTH = 2**ADDR_SIZE;
    logic [DEPTH-1:0] pend;
    logic             issue_ok;
    // A writeback landing this cycle resolves the hazard without a stall.
    assign rd_stall    = rd_en && ((pend[sr1] && !(ld && dr == sr1)) || (pend[sr2] && !(ld && dr == sr2)));
    assign issue_stall = issue_en && pend[issue_dr] && !(ld && dr == issue_dr);
    assign issue_ok    = issue_en && !issue_stall && !(ZERO_REG != 0 && issue_dr == '0);
    // Set after clear: a same-cycle issue keeps the register pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (ld) pend[dr] <= 1'b0;
            if (issue_ok) pend[issue_dr] <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with registered bypassed reads and write scoreboard
//   clk, rst (async, active high); bus: regfile_sb_if.slave
//   Optional condition codes on writeback when REGFILE_CC_EN is defined, else cc_nzp = 0.
module regfile_sb import regfile_pkg::*; #(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int ZERO_REG  = 0
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2**ADDR_SIZE;
    logic [DATA_SIZE-1:0] regs [DEPTH];
    logic                 wr_ok, rd_ok;
    logic [DATA_SIZE-1:0] val1, val2;
    // R0 is never written when hardwired, so it reads as its reset value 0.
    assign wr_ok = bus.ld && !(ZERO_REG != 0 && bus.dr == '0);
    assign val1  = (wr_ok && bus.dr == bus.sr1) ? bus.dr_in : regs[bus.sr1];
    assign val2  = (wr_ok && bus.dr == bus.sr2) ? bus.dr_in : regs[bus.sr2];
    assign rd_ok = bus.rd_en && !bus.rd_stall;
    regfile_scoreboard #(.ADDR_SIZE(ADDR_SIZE), .ZERO_REG(ZERO_REG)) u_sb (
        .clk(clk), .rst(rst), .sr1(bus.sr1), .sr2(bus.sr2), .rd_en(bus.rd_en),
        .issue_en(bus.issue_en), .issue_dr(bus.issue_dr), .ld(bus.ld), .dr(bus.dr),
        .rd_stall(bus.rd_stall), .issue_stall(bus.issue_stall)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs <= '{default: '0};
        else if (wr_ok) regs[bus.dr] <= bus.dr_in;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sr1_out  <= '0;
            bus.sr2_out  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= rd_ok;
            if (rd_ok) begin
                bus.sr1_out <= val1;
                bus.sr2_out <= val2;
            end
        end
    end
`ifdef REGFILE_CC_EN
    // Codes follow every writeback, including a discarded R0 write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.cc_nzp <= CC_RST;
        else if (bus.ld) bus.cc_nzp <= nzp_of(bus.dr_in[DATA_SIZE-1], bus.dr_in == '0);
    end
`else
    assign bus.cc_nzp = '0;
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against a reference model and read scoreboard
module tb_regfile_sb;
    import regfile_pkg::*;
`ifdef REGFILE_CC_EN
    localparam bit CC_ON = 1'b1;
`else
    localparam bit CC_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    regfile_sb_if #(.DATA_SIZE(16), .ADDR_SIZE(3)) bus ();
    regfile_sb_if #(.DATA_SIZE(16), .ADDR_SIZE(3)) bz ();
    regfile_sb #(.DATA_SIZE(16), .ADDR_SIZE(3), .ZERO_REG(0)) dut (.clk(clk), .rst(rst), .bus(bus));
    regfile_sb #(.DATA_SIZE(16), .ADDR_SIZE(3), .ZERO_REG(1)) dut_z (.clk(clk), .rst(rst), .bus(bz));
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_reg [8];
    logic [7:0]  m_pend;
    logic [15:0] m_o1, m_o2;
    nzp_t        m_cc;
    logic [31:0] sb_q [$];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = '0;
        m_pend = '0;
        m_o1 = '0;
        m_o2 = '0;
        m_cc = CC_ON ? 3'b010 : 3'b000;
        sb_q.delete();
    endtask
    task automatic idle();
        bus.rd_en = 0; bus.sr1 = 0; bus.sr2 = 0;
        bus.issue_en = 0; bus.issue_dr = 0;
        bus.ld = 0; bus.dr = 0; bus.dr_in = 0;
    endtask
    task automatic zidle();
        bz.rd_en = 0; bz.sr1 = 0; bz.sr2 = 0;
        bz.issue_en = 0; bz.issue_dr = 0;
        bz.ld = 0; bz.dr = 0; bz.dr_in = 0;
    endtask
    function automatic logic [15:0] rv(input logic [2:0] a);
        return (bus.ld && bus.dr == a) ? bus.dr_in : m_reg[a];
    endfunction
    // One clock of the main DUT: check stalls, push expected read data, advance model, pop and compare.
    task automatic tick(input string tag);
        logic        e_rs, e_is, e_v;
        logic [31:0] got;
        #1;
        e_rs = bus.rd_en && ((m_pend[bus.sr1] && !(bus.ld && bus.dr == bus.sr1)) ||
                             (m_pend[bus.sr2] && !(bus.ld && bus.dr == bus.sr2)));
        e_is = bus.issue_en && m_pend[bus.issue_dr] && !(bus.ld && bus.dr == bus.issue_dr);
        check({tag, ".rd_stall"}, bus.rd_stall, e_rs);
        check({tag, ".issue_stall"}, bus.issue_stall, e_is);
        e_v = bus.rd_en && !e_rs;
        if (e_v) sb_q.push_back({rv(bus.sr1), rv(bus.sr2)});
        if (bus.ld) begin
            m_reg[bus.dr] = bus.dr_in;
            m_pend[bus.dr] = 1'b0;
            if (CC_ON) m_cc = {bus.dr_in[15], bus.dr_in == 16'h0, !bus.dr_in[15] && bus.dr_in != 16'h0};
        end
        if (bus.issue_en && !e_is) m_pend[bus.issue_dr] = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".rd_valid"}, bus.rd_valid, e_v);
        if (bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check({tag, ".sb_empty"}, 32'd0, 32'd1);
            end else begin
                got = sb_q.pop_front();
                m_o1 = got[31:16];
                m_o2 = got[15:0];
            end
        end
        check({tag, ".sr1_out"}, bus.sr1_out, m_o1);
        check({tag, ".sr2_out"}, bus.sr2_out, m_o2);
        check({tag, ".cc_nzp"}, bus.cc_nzp, m_cc);
    endtask
    task automatic ztick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        idle();
        zidle();
        model_reset();
        #12 rst = 1'b0;
        #1;
        check("reset.sr1_out", bus.sr1_out, 16'h0);
        check("reset.sr2_out", bus.sr2_out, 16'h0);
        check("reset.rd_valid", bus.rd_valid, 1'b0);
        check("reset.cc_nzp", bus.cc_nzp, CC_ON ? 3'b010 : 3'b000);
        bus.rd_en = 1; bus.sr1 = 3; bus.sr2 = 7;
        tick("rst_rd");
        idle();
        tick("idle");
        bus.ld = 1; bus.dr = 5; bus.dr_in = 16'h1234;
        tick("wr5");
        idle();
        bus.rd_en = 1; bus.sr1 = 5;
        tick("rd5");
        check("rd5.const", bus.sr1_out, 16'h1234);
        #1 rst = 1'b1;
        #1;
        check("midrst.sr1_out", bus.sr1_out, 16'h0);
        check("midrst.rd_valid", bus.rd_valid, 1'b0);
        check("midrst.cc_nzp", bus.cc_nzp, CC_ON ? 3'b010 : 3'b000);
        model_reset();
        rst = 1'b0;
        idle();
        bus.rd_en = 1; bus.sr1 = 5;
        tick("rd5_after_rst");
        idle();
        bus.ld = 1; bus.dr = 2; bus.dr_in = 16'hBEEF; bus.rd_en = 1; bus.sr2 = 2;
        tick("bypass");
        check("bypass.const", bus.sr2_out, 16'hBEEF);
        idle();
        bus.issue_en = 1; bus.issue_dr = 4;
        tick("issue4");
        idle();
        bus.rd_en = 1; bus.sr1 = 4;
        tick("stall4");
        bus.ld = 1; bus.dr = 4; bus.dr_in = 16'h0042;
        tick("resolve4");
        check("resolve4.const", bus.sr1_out, 16'h0042);
        idle();
        bus.issue_en = 1; bus.issue_dr = 6;
        tick("issue6a");
        tick("issue6b");
        idle();
        bus.rd_en = 1; bus.sr2 = 6;
        tick("rd6_pend");
        idle();
        bus.issue_en = 1; bus.issue_dr = 6; bus.ld = 1; bus.dr = 6; bus.dr_in = 16'h0666;
        tick("issue_wb6");
        idle();
        bus.rd_en = 1; bus.sr1 = 6;
        tick("rd6_still_pend");
        idle();
        bus.ld = 1; bus.dr = 6; bus.dr_in = 16'h0777;
        tick("wb6");
        idle();
        bus.rd_en = 1; bus.sr1 = 6; bus.sr2 = 2;
        tick("rd6");
        idle();
        bus.ld = 1; bus.dr = 1; bus.dr_in = 16'h8000;
        tick("cc_neg");
        check("cc_neg.const", bus.cc_nzp, CC_ON ? 3'b100 : 3'b000);
        bus.dr_in = 16'h0000;
        tick("cc_zero");
        check("cc_zero.const", bus.cc_nzp, CC_ON ? 3'b010 : 3'b000);
        bus.dr_in = 16'h0001;
        tick("cc_pos");
        check("cc_pos.const", bus.cc_nzp, CC_ON ? 3'b001 : 3'b000);
        for (int i = 0; i < 60; i++) begin
            bus.rd_en    = 1'($urandom_range(0, 1));
            bus.sr1      = 3'($urandom_range(0, 7));
            bus.sr2      = 3'($urandom_range(0, 7));
            bus.issue_en = 1'($urandom_range(0, 1));
            bus.issue_dr = 3'($urandom_range(0, 7));
            bus.ld       = 1'($urandom_range(0, 1));
            bus.dr       = 3'($urandom_range(0, 7));
            bus.dr_in    = 16'($urandom);
            tick("rand");
        end
        idle();
        bz.ld = 1; bz.dr = 1; bz.dr_in = 16'h5555; bz.rd_en = 1; bz.sr1 = 1; bz.sr2 = 1;
        ztick();
        check("z.r1.sr1_out", bz.sr1_out, 16'h5555);
        zidle();
        bz.ld = 1; bz.dr = 0; bz.dr_in = 16'hFFFF; bz.rd_en = 1; bz.sr1 = 0; bz.sr2 = 1;
        ztick();
        check("z.r0_byp.sr1_out", bz.sr1_out, 16'h0);
        check("z.r0_byp.sr2_out", bz.sr2_out, 16'h5555);
        check("z.r0_byp.cc_nzp", bz.cc_nzp, CC_ON ? 3'b100 : 3'b000);
        zidle();
        bz.issue_en = 1; bz.issue_dr = 0;
        #1 check("z.issue0a", bz.issue_stall, 1'b0);
        ztick();
        check("z.issue0b", bz.issue_stall, 1'b0);
        zidle();
        bz.rd_en = 1; bz.sr1 = 0; bz.sr2 = 0;
        #1 check("z.rd0.rd_stall", bz.rd_stall, 1'b0);
        ztick();
        check("z.rd0.sr1_out", bz.sr1_out, 16'h0);
        check("z.rd0.sr2_out", bz.sr2_out, 16'h0);
        check("z.rd0.rd_valid", bz.rd_valid, 1'b1);
        zidle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
